tlul_reg_fifo: RTL and testbench
================================

// Module: tlul_reg_fifo
// PURPOSE
// - Buffer stage directly upstream of the TL-UL register adapter.
// - Decouples host and register-block timing:
//   - A-channel request FIFO (host -> adapter).
//   - D-channel response FIFO (adapter -> host).
// - Breaks the combinational a_ready/d_ready paths so reg_top timing closes
//   behind a crossbar.
// - Transparent to protocol: fields pass unmodified and in order.
// PARAMETERS
// - ReqDepth  2  A-channel entries; 0 = combinational pass-through, otherwise >= 2.
// - RspDepth  2  D-channel entries; 0 = combinational pass-through, otherwise >= 2.
// PORTS
// - clk_i      in   1                   clock; all state on rising edge
// - rst_i      in   1                   reset, synchronous, active-high
// - tl_h_i     in   tl_h2d_t            host-side request (a_*), d_ready
// - tl_h_o     out  tl_d2h_t            host-side response (d_*), a_ready
// - tl_d_o     out  tl_h2d_t            device-side request to the adapter
// - tl_d_i     in   tl_d2h_t            device-side response from the adapter
// - req_lvl_o  out  $clog2(ReqDepth+1)  A FIFO occupancy
// - rsp_lvl_o  out  $clog2(RspDepth+1)  D FIFO occupancy
// BEHAVIOUR
// - One clock, clk_i. Reset is synchronous and active-high on rst_i.
// - Reset: pointers and counts clear on the first clk_i edge with rst_i=1.
//   - From then until release: tl_h_o.a_ready=1, tl_h_o.d_valid=0.
//   - tl_d_o.a_valid=0, tl_d_o.d_ready=1.
//   - req_lvl_o=0, rsp_lvl_o=0.
//   - Payload outputs drive '0 while their FIFO is empty.
// - A push is a_valid & a_ready on the host side. A pop is a_valid & a_ready
//   on the device side. The D channel uses d_valid/d_ready the same way.
// - The stored A word is the whole tl_h2d_t minus d_ready. It is packed via
//   $bits, so a_user and integrity bits are preserved bit-exact.
// - The stored D word is tl_d2h_t minus a_ready.
// - Request FIFO (Depth >= 2):
//   - tl_h_o.a_ready = ~full. This is registered state only, with no
//     combinational path from tl_d_i.a_ready.
//   - tl_d_o.a_valid = ~empty. tl_d_o.a_* = head entry.
//   - Latency: a push in cycle N is visible on tl_d_o in cycle N+1. There is
//     no same-cycle fall-through.
// - Response FIFO: mirror of the request FIFO.
//   - tl_d_o.d_ready = ~full.
//   - tl_h_o.d_valid = ~empty.
// - Depth = 0 (pass-through):
//   - The valid/ready/payload wires connect straight through.
//   - The level output is tied 0.
// - Pointers wrap from Depth-1 to 0 (any Depth >= 2, not only powers of 2).
// - Count width: $clog2(Depth+1).
// - Simultaneous push and pop:
//   - When not empty and not full: count unchanged, both pointers advance.
//   - When full: a_ready=0, so only the pop happens. The push is accepted
//     next cycle.
//   - When empty: only the push happens. The pop is impossible since valid=0.
// - Ordering: strict FIFO per channel. The block never reorders or drops.
// - The block never alters a_source or d_source.
// - Holding: while tl_d_o.a_valid=1 and tl_d_i.a_ready=0, head contents stay
//   stable (TL-UL rule). The same holds for D.
// - Reset mid-operation:
//   - All buffered requests and responses are discarded.
//   - Valids drop in the cycle after the reset edge.
//   - Upstream and downstream blocks are reset in the same domain and
//     therefore hold no stale outstanding state.
// - Storage is not reset, only pointers. Empty-gating of payloads hides
//   stale data.
// STRUCTURE
// - Shared in tlul_pkg:
//   - tl_h2d_t and tl_d2h_t (existing).
//   - New localparams TL_A_PKT_W and TL_D_PKT_W: packed widths of the stored
//     channel words.
//   - Pack/unpack functions tl_a_pack/tl_a_unpack and tl_d_pack/tl_d_unpack.
// - One sub-module: tlul_sync_fifo #(Width, Depth).
//   - Ports: clk_i, rst_i, wvalid_i, wready_o, wdata_i, rvalid_o, rready_i,
//     rdata_o, lvl_o.
//   - Instantiated twice, once per channel.
//   - Owns the pointers, count, storage and Depth=0 bypass.
// TESTING
// - Reset release: rst_i 1->0 -> a_ready=1, d_valid=0, tl_d_o.a_valid=0,
//   d_ready=1, both levels 0.
// - Single Get:
//   - Stimulus: host sends Get, addr 0x10, source 3, size 2 in cycle N.
//   - A side: tl_d_o.a_valid=1 in N+1 with identical fields, req_lvl 1->0
//     after device ack.
//   - D side: device returns AccessAckData, data 0xDEADBEEF, source 3 ->
//     host sees the same in the next cycle.
// - Full/backpressure:
//   - Stimulus: device a_ready=0, host pushes 3 writes.
//   - After 2 pushes: req_lvl=2 and a_ready=0.
//   - The third write is held. On a_ready=1, all three emerge in order:
//     data 0x1, 0x2, 0x3.
// - Simultaneous push/pop at lvl=1: push and pop in the same cycle -> lvl
//   stays 1, head advances, no loss.
//   - Repeat at lvl=2: pop only, lvl->1.
// - Wrap-around: with ReqDepth=3, stream 10 back-to-back requests with random
//   device stalls -> all 10 arrive in order with matching a_source 0..9.
// - Mid-operation reset:
//   - Stimulus: 2 requests and 1 response buffered, then rst_i pulse.
//   - Next cycle: both valids=0 and levels=0.
//   - After release: a new Get completes normally.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL channel types plus pack/unpack helpers for the stored FIFO words.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [4:0] rsvd;
        logic [3:0] instr_type;
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    // a_valid is the MSB and d_ready the LSB; the stored word is everything between.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    localparam int unsigned TL_H2D_W   = $bits(tl_h2d_t);
    localparam int unsigned TL_D2H_W   = $bits(tl_d2h_t);
    localparam int unsigned TL_A_PKT_W = TL_H2D_W - 2;
    localparam int unsigned TL_D_PKT_W = TL_D2H_W - 2;

    function automatic int unsigned lvl_w(input int unsigned depth);
        return (depth == 0) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic logic [TL_A_PKT_W-1:0] tl_a_pack(input tl_h2d_t h);
        logic [TL_H2D_W-1:0] raw;
        raw = h;
        return raw[TL_A_PKT_W:1];
    endfunction

    function automatic tl_h2d_t tl_a_unpack(input logic [TL_A_PKT_W-1:0] pkt,
                                            input logic a_valid, input logic d_ready);
        logic [TL_H2D_W-1:0] raw;
        raw = {a_valid, pkt, d_ready};
        return tl_h2d_t'(raw);
    endfunction

    function automatic logic [TL_D_PKT_W-1:0] tl_d_pack(input tl_d2h_t d);
        logic [TL_D2H_W-1:0] raw;
        raw = d;
        return raw[TL_D_PKT_W:1];
    endfunction

    function automatic tl_d2h_t tl_d_unpack(input logic [TL_D_PKT_W-1:0] pkt,
                                            input logic d_valid, input logic a_ready);
        logic [TL_D2H_W-1:0] raw;
        raw = {d_valid, pkt, a_ready};
        return tl_d2h_t'(raw);
    endfunction

endpackage

// File: rtl/tlul_reg_fifo_if.sv
// One TL-UL link: request toward the device, response back toward the host.
interface tlul_reg_fifo_if;
    tlul_pkg::tl_h2d_t h2d;
    tlul_pkg::tl_d2h_t d2h;

    modport master (output h2d, input d2h);
    modport slave  (input h2d, output d2h);
endinterface

// File: rtl/tlul_sync_fifo.sv
// Single-clock valid/ready FIFO with registered ready/valid; Depth=0 is a wire.
module tlul_sync_fifo
    import tlul_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      wvalid_i,
    output logic                      wready_o,
    input  logic [Width-1:0]          wdata_i,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic [Width-1:0]          rdata_o,
    output logic [lvl_w(Depth)-1:0]   lvl_o
);

    localparam int unsigned LvlW = lvl_w(Depth);

    if (Depth == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign wready_o = rready_i;
        assign rvalid_o = wvalid_i;
        assign rdata_o  = wdata_i;
        assign lvl_o    = '0;
    end else begin : g_fifo
        localparam int unsigned PtrW = (Depth <= 2) ? 1 : $clog2(Depth);

        logic [Width-1:0] mem [Depth];
        logic [PtrW-1:0]  wptr, rptr;
        logic [LvlW-1:0]  cnt;
        logic             full, empty, push, pop;

        assign full  = (cnt == LvlW'(Depth));
        assign empty = (cnt == '0);
        assign push  = wvalid_i & ~full;
        assign pop   = ~empty & rready_i;

        // Pointers wrap explicitly so non-power-of-2 depths work.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wptr <= '0;
                rptr <= '0;
                cnt  <= '0;
            end else begin
                if (push) wptr <= (wptr == PtrW'(Depth - 1)) ? '0 : wptr + PtrW'(1);
                if (pop)  rptr <= (rptr == PtrW'(Depth - 1)) ? '0 : rptr + PtrW'(1);
                case ({push, pop})
                    2'b10:   cnt <= cnt + LvlW'(1);
                    2'b01:   cnt <= cnt - LvlW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end

        // Storage is deliberately unreset; empty-gating hides stale words.
        always_ff @(posedge clk_i) begin
            if (push) mem[wptr] <= wdata_i;
        end

        assign wready_o = ~full;
        assign rvalid_o = ~empty;
        assign rdata_o  = empty ? '0 : mem[rptr];
        assign lvl_o    = cnt;
    end

endmodule

// File: rtl/tlul_reg_fifo.sv
// Request/response buffer in front of the TL-UL register adapter.
module tlul_reg_fifo
    import tlul_pkg::*;
#(
    parameter int unsigned ReqDepth = 2,
    parameter int unsigned RspDepth = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    tlul_reg_fifo_if.slave               tl_h,
    tlul_reg_fifo_if.master              tl_d,
    output logic [lvl_w(ReqDepth)-1:0]   req_lvl_o,
    output logic [lvl_w(RspDepth)-1:0]   rsp_lvl_o
);

    logic                  req_wready, req_rvalid;
    logic [TL_A_PKT_W-1:0] req_rdata;
    logic                  rsp_wready, rsp_rvalid;
    logic [TL_D_PKT_W-1:0] rsp_rdata;

    tlul_sync_fifo #(
        .Width (TL_A_PKT_W),
        .Depth (ReqDepth)
    ) u_req_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (tl_h.h2d.a_valid),
        .wready_o (req_wready),
        .wdata_i  (tl_a_pack(tl_h.h2d)),
        .rvalid_o (req_rvalid),
        .rready_i (tl_d.d2h.a_ready),
        .rdata_o  (req_rdata),
        .lvl_o    (req_lvl_o)
    );

    tlul_sync_fifo #(
        .Width (TL_D_PKT_W),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (tl_d.d2h.d_valid),
        .wready_o (rsp_wready),
        .wdata_i  (tl_d_pack(tl_d.d2h)),
        .rvalid_o (rsp_rvalid),
        .rready_i (tl_h.h2d.d_ready),
        .rdata_o  (rsp_rdata),
        .lvl_o    (rsp_lvl_o)
    );

    // Each channel's handshake bits are reattached around its stored word.
    assign tl_d.h2d = tl_a_unpack(req_rdata, req_rvalid, rsp_wready);
    assign tl_h.d2h = tl_d_unpack(rsp_rdata, rsp_rvalid, req_wready);

endmodule

// File: tb/tb_tlul_reg_fifo.sv
// Self-checking bench for tlul_reg_fifo: vector table, scoreboards, corner sequences.
module tb_tlul_reg_fifo;
    import tlul_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_lvl, rsp_lvl, req_lvl3, rsp_lvl3;
    int         checks = 0;
    int         failures = 0;
    int         rx3 = 0;

    tlul_reg_fifo_if h_if ();
    tlul_reg_fifo_if d_if ();
    tlul_reg_fifo_if h3_if ();
    tlul_reg_fifo_if d3_if ();

    tlul_reg_fifo #(.ReqDepth(2), .RspDepth(2)) dut (
        .clk_i(clk), .rst_i(rst), .tl_h(h_if), .tl_d(d_if),
        .req_lvl_o(req_lvl), .rsp_lvl_o(rsp_lvl)
    );

    tlul_reg_fifo #(.ReqDepth(3), .RspDepth(2)) dut3 (
        .clk_i(clk), .rst_i(rst), .tl_h(h3_if), .tl_d(d3_if),
        .req_lvl_o(req_lvl3), .rsp_lvl_o(rsp_lvl3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [7:0]  src;
        logic [1:0]  size;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [22:0] user;
        logic [2:0]  rop;
        logic [31:0] rdata;
        logic        rerr;
    } vec_t;

    logic [TL_A_PKT_W-1:0] a_q[$];
    logic [TL_D_PKT_W-1:0] d_q[$];
    logic [TL_A_PKT_W-1:0] a3_q[$];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic tl_h2d_t mk_a(input logic [2:0] op, input logic [31:0] addr,
                                     input logic [7:0] src, input logic [1:0] size,
                                     input logic [3:0] mask, input logic [31:0] data,
                                     input logic [22:0] user);
        tl_h2d_t h;
        h = '0;
        h.a_valid   = 1'b1;
        h.a_opcode  = op;
        h.a_source  = src;
        h.a_address = addr;
        h.a_size    = size;
        h.a_mask    = mask;
        h.a_data    = data;
        h.a_user    = tl_a_user_t'(user);
        return h;
    endfunction

    function automatic tl_d2h_t mk_d(input logic [2:0] op, input logic [7:0] src,
                                     input logic [1:0] size, input logic [31:0] data,
                                     input logic err);
        tl_d2h_t d;
        d = '0;
        d.d_valid  = 1'b1;
        d.d_opcode = op;
        d.d_source = src;
        d.d_size   = size;
        d.d_data   = data;
        d.d_error  = err;
        d.d_user   = tl_d_user_t'(14'h2A55);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: expected words queued on each ingress handshake, checked on egress.
    always @(posedge clk) begin
        if (rst) begin
            a_q.delete();
            d_q.delete();
            a3_q.delete();
        end else begin
            if (h_if.h2d.a_valid && h_if.d2h.a_ready) a_q.push_back(tl_a_pack(h_if.h2d));
            if (d_if.h2d.a_valid && d_if.d2h.a_ready) begin
                checks++;
                if (a_q.size() == 0 || a_q[0] !== tl_a_pack(d_if.h2d)) begin
                    failures++;
                    $display("FAIL sb_a: got 0x%0h expected 0x%0h (queued %0d)",
                             tl_a_pack(d_if.h2d), (a_q.size() != 0) ? a_q[0] : '0, a_q.size());
                end
                if (a_q.size() != 0) void'(a_q.pop_front());
            end
            if (d_if.d2h.d_valid && d_if.h2d.d_ready) d_q.push_back(tl_d_pack(d_if.d2h));
            if (h_if.d2h.d_valid && h_if.h2d.d_ready) begin
                checks++;
                if (d_q.size() == 0 || d_q[0] !== tl_d_pack(h_if.d2h)) begin
                    failures++;
                    $display("FAIL sb_d: got 0x%0h expected 0x%0h (queued %0d)",
                             tl_d_pack(h_if.d2h), (d_q.size() != 0) ? d_q[0] : '0, d_q.size());
                end
                if (d_q.size() != 0) void'(d_q.pop_front());
            end
            if (h3_if.h2d.a_valid && h3_if.d2h.a_ready) a3_q.push_back(tl_a_pack(h3_if.h2d));
            if (d3_if.h2d.a_valid && d3_if.d2h.a_ready) begin
                chk("wrap_src_order", 64'(d3_if.h2d.a_source), 64'(rx3));
                checks++;
                if (a3_q.size() == 0 || a3_q[0] !== tl_a_pack(d3_if.h2d)) begin
                    failures++;
                    $display("FAIL sb_a3: got 0x%0h expected 0x%0h (queued %0d)",
                             tl_a_pack(d3_if.h2d), (a3_q.size() != 0) ? a3_q[0] : '0, a3_q.size());
                end
                if (a3_q.size() != 0) void'(a3_q.pop_front());
                rx3++;
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_a_ready"},   64'(h_if.d2h.a_ready), 64'(1));
        chk({tag, "_d_valid"},   64'(h_if.d2h.d_valid), 64'(0));
        chk({tag, "_dev_avalid"}, 64'(d_if.h2d.a_valid), 64'(0));
        chk({tag, "_dev_dready"}, 64'(d_if.h2d.d_ready), 64'(1));
        chk({tag, "_req_lvl"},   64'(req_lvl), 64'(0));
        chk({tag, "_rsp_lvl"},   64'(rsp_lvl), 64'(0));
    endtask

    vec_t vecs[4];
    int   sent;
    int   cyc;
    logic acc;

    initial begin
        vecs[0] = '{Get,            32'h0000_0010, 8'd3,   2'd2, 4'hF, 32'h0,         23'h0,
                    AccessAckData, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{PutFullData,    32'h0000_0020, 8'd5,   2'd2, 4'hF, 32'hA5A5_5A5A, 23'h01_2345,
                    AccessAck,     32'h0,         1'b0};
        vecs[2] = '{PutPartialData, 32'h0000_01FC, 8'hFF,  2'd1, 4'h3, 32'h0000_BEEF, 23'h7F_FFFF,
                    AccessAck,     32'h0,         1'b0};
        vecs[3] = '{Get,            32'hFFFF_FFFC, 8'd0,   2'd2, 4'hF, 32'h0,         23'h55_AAAA,
                    AccessAckData, 32'hFFFF_FFFF, 1'b1};

        h_if.h2d  = '0;
        d_if.d2h  = '0;
        h3_if.h2d = '0;
        d3_if.d2h = '0;
        rst = 1'b1;
        tick();
        tick();
        chk_idle("in_reset");
        rst = 1'b0;
        tick();
        chk_idle("reset_release");

        // Table-driven single transactions through both channels.
        for (int i = 0; i < 4; i++) begin
            h_if.h2d = mk_a(vecs[i].op, vecs[i].addr, vecs[i].src, vecs[i].size,
                            vecs[i].mask, vecs[i].wdata, vecs[i].user);
            tick();
            h_if.h2d.a_valid = 1'b0;
            chk("vec_dev_avalid", 64'(d_if.h2d.a_valid),   64'(1));
            chk("vec_opcode",     64'(d_if.h2d.a_opcode),  64'(vecs[i].op));
            chk("vec_addr",       64'(d_if.h2d.a_address), 64'(vecs[i].addr));
            chk("vec_source",     64'(d_if.h2d.a_source),  64'(vecs[i].src));
            chk("vec_size",       64'(d_if.h2d.a_size),    64'(vecs[i].size));
            chk("vec_mask",       64'(d_if.h2d.a_mask),    64'(vecs[i].mask));
            chk("vec_wdata",      64'(d_if.h2d.a_data),    64'(vecs[i].wdata));
            chk("vec_user",       64'(d_if.h2d.a_user),    64'(vecs[i].user));
            chk("vec_req_lvl1",   64'(req_lvl),            64'(1));

            d_if.d2h.a_ready = 1'b1;
            tick();
            d_if.d2h.a_ready = 1'b0;
            chk("vec_req_lvl0",   64'(req_lvl),            64'(0));
            chk("vec_avalid_off", 64'(d_if.h2d.a_valid),   64'(0));
            chk("vec_a_gated",    64'(d_if.h2d.a_data),    64'(0));

            d_if.d2h = mk_d(vecs[i].rop, vecs[i].src, vecs[i].size, vecs[i].rdata, vecs[i].rerr);
            tick();
            d_if.d2h.d_valid = 1'b0;
            chk("vec_d_valid",    64'(h_if.d2h.d_valid),   64'(1));
            chk("vec_d_opcode",   64'(h_if.d2h.d_opcode),  64'(vecs[i].rop));
            chk("vec_d_data",     64'(h_if.d2h.d_data),    64'(vecs[i].rdata));
            chk("vec_d_source",   64'(h_if.d2h.d_source),  64'(vecs[i].src));
            chk("vec_d_error",    64'(h_if.d2h.d_error),   64'(vecs[i].rerr));
            chk("vec_rsp_lvl1",   64'(rsp_lvl),            64'(1));
            chk("vec_dev_dready", 64'(d_if.h2d.d_ready),   64'(1));

            h_if.h2d.d_ready = 1'b1;
            tick();
            h_if.h2d.d_ready = 1'b0;
            chk("vec_rsp_lvl0",   64'(rsp_lvl),            64'(0));
            chk("vec_d_off",      64'(h_if.d2h.d_valid),   64'(0));
            chk("vec_d_gated",    64'(h_if.d2h.d_data),    64'(0));
        end

        // Full/backpressure, then push+pop at full and at level 1.
        h_if.h2d = mk_a(PutFullData, 32'h100, 8'd1, 2'd2, 4'hF, 32'h1, 23'h0);
        tick();
        h_if.h2d = mk_a(PutFullData, 32'h104, 8'd2, 2'd2, 4'hF, 32'h2, 23'h0);
        tick();
        chk("full_lvl2",      64'(req_lvl),            64'(2));
        chk("full_a_ready0",  64'(h_if.d2h.a_ready),   64'(0));
        h_if.h2d = mk_a(PutFullData, 32'h108, 8'd3, 2'd2, 4'hF, 32'h3, 23'h0);
        tick();
        chk("held_lvl2",      64'(req_lvl),            64'(2));
        chk("held_a_ready0",  64'(h_if.d2h.a_ready),   64'(0));
        chk("held_head1",     64'(d_if.h2d.a_data),    64'(1));
        d_if.d2h.a_ready = 1'b1;
        tick();
        chk("popfull_lvl1",   64'(req_lvl),            64'(1));
        chk("popfull_ready",  64'(h_if.d2h.a_ready),   64'(1));
        chk("popfull_head2",  64'(d_if.h2d.a_data),    64'(2));
        tick();
        chk("pushpop_lvl1",   64'(req_lvl),            64'(1));
        chk("pushpop_head3",  64'(d_if.h2d.a_data),    64'(3));
        h_if.h2d.a_valid = 1'b0;
        tick();
        chk("drain_lvl0",     64'(req_lvl),            64'(0));
        d_if.d2h.a_ready = 1'b0;

        // Mid-operation reset with two requests and one response buffered.
        h_if.h2d = mk_a(Get, 32'h200, 8'd7, 2'd2, 4'hF, 32'h0, 23'h0);
        d_if.d2h = mk_d(AccessAck, 8'd9, 2'd2, 32'h0, 1'b0);
        tick();
        h_if.h2d = mk_a(Get, 32'h204, 8'd8, 2'd2, 4'hF, 32'h0, 23'h0);
        d_if.d2h.d_valid = 1'b0;
        tick();
        h_if.h2d.a_valid = 1'b0;
        chk("mid_req_lvl2",   64'(req_lvl),            64'(2));
        chk("mid_rsp_lvl1",   64'(rsp_lvl),            64'(1));
        rst = 1'b1;
        tick();
        chk_idle("mid_reset");
        rst = 1'b0;
        tick();
        h_if.h2d = mk_a(Get, 32'h10, 8'd3, 2'd2, 4'hF, 32'h0, 23'h0);
        tick();
        h_if.h2d.a_valid = 1'b0;
        chk("post_rst_avalid", 64'(d_if.h2d.a_valid),  64'(1));
        chk("post_rst_addr",   64'(d_if.h2d.a_address), 64'(32'h10));
        chk("post_rst_src",    64'(d_if.h2d.a_source), 64'(3));
        chk("post_rst_lvl",    64'(req_lvl),           64'(1));
        d_if.d2h.a_ready = 1'b1;
        tick();
        d_if.d2h.a_ready = 1'b0;
        d_if.d2h = mk_d(AccessAckData, 8'd3, 2'd2, 32'hDEAD_BEEF, 1'b0);
        tick();
        d_if.d2h.d_valid = 1'b0;
        chk("post_rst_ddata",  64'(h_if.d2h.d_data),   64'(32'hDEAD_BEEF));
        chk("post_rst_dsrc",   64'(h_if.d2h.d_source), 64'(3));
        h_if.h2d.d_ready = 1'b1;
        tick();
        h_if.h2d.d_ready = 1'b0;
        chk_idle("post_rst_done");

        // Depth-3 wrap-around: 10 back-to-back requests under random device stalls.
        sent = 0;
        cyc  = 0;
        h3_if.h2d.d_ready = 1'b1;
        while ((sent < 10 || rx3 < 10) && cyc < 400) begin
            if (sent < 10) h3_if.h2d = mk_a(Get, 32'(sent * 4), 8'(sent), 2'd2, 4'hF, 32'(sent), 23'h0);
            else           h3_if.h2d.a_valid = 1'b0;
            d3_if.d2h.a_ready = 1'($urandom_range(0, 1));
            acc = h3_if.h2d.a_valid && h3_if.d2h.a_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        h3_if.h2d.a_valid = 1'b0;
        d3_if.d2h.a_ready = 1'b0;
        chk("wrap_sent",      64'(sent),               64'(10));
        chk("wrap_received",  64'(rx3),                64'(10));
        chk("wrap_lvl0",      64'(req_lvl3),           64'(0));

        chk("sb_a_empty",     64'(a_q.size()),         64'(0));
        chk("sb_d_empty",     64'(d_q.size()),         64'(0));
        chk("sb_a3_empty",    64'(a3_q.size()),        64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
